// File: rtl/botao_pkg.sv
// Shared constants for the push-button conditioning path (pin 2 button -> pin 13 LED).
package botao_pkg;

  localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 16;
  localparam int unsigned DEBOUNCE_CICLOS_SIM    = 4;

  localparam logic NIVEL_PRESSIONADO = 1'b1;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, synchronous active-high reset.
module sincronizador_2ff (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic saida
);

  logic sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      saida <= 1'b0;
    end else begin
      sync1 <= entrada;
      saida <= sync1;
    end
  end

endmodule

// File: rtl/debounce_botao.sv
// Button conditioner: synchronise pino2, debounce with a consecutive-sample counter,
// and produce a clean level, a one-cycle press pulse and a press-parity toggle for pino13.
module debounce_botao
  import botao_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic pino2,
  output logic botao_estavel,
  output logic botao_pulso,
  output logic led_toggle
);

  localparam int CONT_W = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);

  logic              sync2;
  logic [CONT_W-1:0] contador;

  sincronizador_2ff u_sinc (
    .clk     (clk),
    .rst     (rst),
    .entrada (pino2),
    .saida   (sync2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      contador      <= '0;
      botao_estavel <= 1'b0;
      botao_pulso   <= 1'b0;
      led_toggle    <= 1'b0;
    end else begin
      botao_pulso <= 1'b0;
      if (sync2 == botao_estavel) begin
        // Any return to the stable level discards the partial count.
        contador <= '0;
      end else if (contador == CONT_MAX) begin
        contador      <= '0;
        botao_estavel <= sync2;
        if (sync2 == NIVEL_PRESSIONADO) begin
          botao_pulso <= 1'b1;
          led_toggle  <= ~led_toggle;
        end
      end else begin
        contador <= contador + 1'b1;
      end
    end
  end

endmodule

// File: doc/debounce_botao.md
Name: debounce_botao

Overview:
- Conditions the raw push-button input before it reaches the LED logic (button on pin 2 drives LED on pin 13).
- Synchronises the asynchronous pin, filters contact bounce with a consecutive-sample counter, and produces three outputs:
  - a clean level;
  - a one-cycle press pulse;
  - a toggle bit that the downstream LED stage can consume directly as pino13.

Parameters:
- DEBOUNCE_CICLOS, 16, consecutive clk cycles the synchronised input must differ from the stable level before the level is accepted; legal range 2..2^20.
- CONT_W, $clog2(DEBOUNCE_CICLOS), debounce counter width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- pino2  input  1  raw button pin; asynchronous to clk, bounces; 1 = pressed.
- botao_estavel  output  1  debounced button level.
- botao_pulso  output  1  one-cycle high on each accepted press (0->1 of botao_estavel).
- led_toggle  output  1  inverts on every accepted press; feeds the LED stage / pino13.

Behaviour:
- Reset: one clk edge with rst=1 clears all registers. Outputs after that edge: botao_estavel=0, botao_pulso=0, led_toggle=0.
  - Also cleared: sync1, sync2, contador.
  - rst overrides all other activity, including an in-progress debounce count.
- Synchroniser: two flops, sync1<=pino2, sync2<=sync1. Only sync2 is used downstream; pino2 never reaches other logic.
- Debounce counter, evaluated each edge when rst=0:
  - sync2==botao_estavel -> contador<=0.
  - sync2!=botao_estavel and contador<DEBOUNCE_CICLOS-1 -> contador<=contador+1.
  - sync2!=botao_estavel and contador==DEBOUNCE_CICLOS-1 -> botao_estavel<=sync2, contador<=0.
- Latency: pino2 is set before edge E0 and held. botao_estavel changes at edge E0+DEBOUNCE_CICLOS+1 (first high after that edge). The same latency applies to press and release.
- Glitch rejection: any return of sync2 to the stable level before the count completes resets contador to 0. No partial credit is kept between bounces.
- botao_pulso:
  - Registered.
  - High exactly for the cycle following the edge where botao_estavel goes 0->1.
  - Low otherwise, including on release.
  - Never high two consecutive cycles.
- led_toggle:
  - Inverts on the same edge that sets botao_estavel 0->1.
  - Unchanged on release.
  - Parity of accepted presses since reset.
- Holding the button indefinitely gives exactly one pulse and one toggle; no auto-repeat.
- Counter never wraps: the maximum value is DEBOUNCE_CICLOS-1, then the level is accepted.
- Simultaneous rst and completing count: rst wins; no pulse, no toggle.

Decomposition:
- Shared package botao_pkg:
  - DEBOUNCE_CICLOS_PADRAO=16;
  - DEBOUNCE_CICLOS_SIM=4, used by benches;
  - localparam for pressed level (1).
- One natural sub-module, sincronizador_2ff: 1-bit input, two flops, synchronous active-high reset. The debounce/edge/toggle logic stays in the top.
- Downstream connection: led_toggle drives pino13.

Test Plan (DEBOUNCE_CICLOS=4):
- Reset: rst=1 for 2 edges with pino2=1 -> all outputs 0 during and immediately after reset; no pulse on release of rst until full latency elapses.
- Clean press: pino2 0->1 before edge E0, held 20 cycles -> botao_estavel=1 after E5, botao_pulso=1 for exactly the cycle after E5, led_toggle=1; no further pulses.
- Bounce:
  - pino2 pattern 1,0,1,1,0,1 (one cycle each), then 1 held -> no acceptance during the pattern;
  - botao_estavel rises 5 edges after the final 0->1; exactly one pulse.
- Release: from pressed state, pino2=0 held -> botao_estavel=0 after 5 edges; botao_pulso stays 0; led_toggle unchanged.
- Toggle sequence: three clean press/release pairs -> led_toggle goes 1,0,1; three pulses total.
- Reset mid-count: press, assert rst at the 3rd counting edge -> contador/outputs 0; after rst drops with pino2 still 1, full 5-edge latency is required again before botao_estavel=1.
